hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage RV32I pipeline (fetch, decode, execute, memory, writeback).
- Watches the register indices and valid bits of instructions in flight and the branch/link redirect signal at the memory stage.
- Produces stall, bubble, squash and operand-forwarding selects for the stage latches.
- Holds a small stall FSM and stall/flush event counters.

Parameters:
- CNT_W, 32, width of the STALL_CNT and FLUSH_CNT event counters (wrap on overflow).

Ports:
CLK  in  1  clock; all state updates on posedge
RST  in  1  asynchronous reset, active-high
EXT_HOLD  in  1  external freeze request (e.g. memory wait); freezes the whole pipeline
DE_V  in  1  decode-latch valid
DE_RS1  in  5  rs1 index of instruction in decode
DE_RS2  in  5  rs2 index of instruction in decode
DE_USE1  in  1  decode instruction reads rs1 (R/I/S/B)
DE_USE2  in  1  decode instruction reads rs2 (R/S/B)
EX_V  in  1  execute-latch valid
EX_RD  in  5  destination index in execute
EX_WE  in  1  execute instruction writes RF (R/I/J/U)
EX_LD  in  1  execute instruction is a load
ME_V  in  1  memory-latch valid
ME_RD  in  5  destination index in memory
ME_WE  in  1  memory instruction writes RF
ME_BRT  in  1  taken branch/jump redirect from memory latch
WB_V  in  1  writeback valid
WB_RD  in  5  destination index in writeback
WB_WE  in  1  writeback instruction writes RF
PC_HOLD  out  1  fetch PC and DE latch keep their value
EX_BUBBLE  out  1  EX latch loads V=0 this edge
KILL_DE  out  1  DE latch loads V=0
KILL_EX  out  1  EX latch loads V=0
KILL_ME  out  1  ME latch loads V=0
FREEZE  out  1  all stage latches and PC hold; WB write suppressed
FWD_A  out  2  registered EX operand-A select: 0 = RS1 latch, 1 = ME_ALU_RE, 2 = WB RF_DATA_IN
FWD_B  out  2  same for operand B
DE_BYP1  out  1  decode rs1 read must take WB RF_DATA_IN (same-cycle RF write)
DE_BYP2  out  1  same for rs2
STALL_CNT  out  CNT_W  count of load-use stall cycles
FLUSH_CNT  out  CNT_W  count of redirects

Behaviour:
- Definitions:
  - hit(v,we,rd,rs) = v & we & (rd!=0) & (rd==rs).
  - redir = ME_V & ME_BRT.
  - luse = EX_V & EX_LD & DE_V & (hit(EX_V,EX_WE,EX_RD,DE_RS1)&DE_USE1 | hit(EX_V,EX_WE,EX_RD,DE_RS2)&DE_USE2).
- Reset (async, RST=1): FSM=RUN, FWD_A=FWD_B=0, STALL_CNT=FLUSH_CNT=0. Every combinational output evaluates to 0 while RST is high.
- FSM states RUN, LDUSE, HOLD. Priority is EXT_HOLD > redir > luse.
  - RUN: EXT_HOLD -> HOLD; else luse & !redir -> LDUSE; else RUN.
  - LDUSE: stays exactly 1 cycle. EXT_HOLD -> HOLD, else -> RUN. A luse re-evaluated in LDUSE is false because the load has moved to ME.
  - HOLD: while EXT_HOLD, FREEZE=1 and no other output or state changes. Counters and FWD regs hold. On release -> RUN and normal evaluation resumes next cycle.
- Combinational outputs (not in HOLD):
  - PC_HOLD = EX_BUBBLE = luse & !redir.
  - KILL_DE = KILL_EX = KILL_ME = redir. Redirect squashes the three younger instructions latched on the same edge the PC redirects.
  - redir together with luse: the squash wins and no stall is taken.
  - DE_BYP1 = hit(WB_V,WB_WE,WB_RD,DE_RS1) & DE_USE1. DE_BYP2 is analogous for rs2.
- FWD registers load on every non-frozen edge (latency 1, aligned with the DE->EX latch):
  - next FWD_A = 1 if hit(EX_V,EX_WE,EX_RD,DE_RS1) & !EX_LD; else 2 if hit(ME_V,ME_WE,ME_RD,DE_RS1); else 0. The nearer producer wins.
  - FWD_B is computed the same way for DE_RS2.
  - On an EX_BUBBLE or KILL_EX edge, FWD_A and FWD_B load 0.
- Counters:
  - STALL_CNT += 1 on each edge with EX_BUBBLE=1.
  - FLUSH_CNT += 1 on each edge with redir=1.
  - Both wrap modulo 2^CNT_W.
- x0 never creates a hazard.
- RST asserted mid-stall: returns to RUN immediately; no residual bubble after release.

Test Plan:
- Back-to-back add x5 then add x6,x5,x1 -> no stall; FWD_A=1 in the dependent's EX cycle; STALL_CNT stays 0.
- lw x5 then add x6,x5,x1 -> exactly one cycle PC_HOLD=EX_BUBBLE=1, FSM RUN->LDUSE->RUN; next EX cycle has FWD_A=2; STALL_CNT=1.
- Taken beq reaching ME with DE/EX/ME valid -> KILL_DE/EX/ME=1 for one cycle; FLUSH_CNT=1. Same cycle with luse true -> PC_HOLD=0.
- Producer in WB and consumer in DE on rs2 -> DE_BYP2=1. Producer rd=x0 -> all forward/bypass/stall signals 0.
- EXT_HOLD for 3 cycles during LDUSE -> FREEZE=1 for 3 cycles; FWD regs and counters unchanged; resumes RUN; STALL_CNT increments only once.
- RST pulsed while in LDUSE with FWD_A=2 -> all outputs 0, counters 0; first post-reset edge evaluates normally.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline: load-use stall,
// redirect squash, operand-forward selects, decode bypass and event counters.
module hazard_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EXT_HOLD,
    input  logic             DE_V,
    input  logic [4:0]       DE_RS1,
    input  logic [4:0]       DE_RS2,
    input  logic             DE_USE1,
    input  logic             DE_USE2,
    input  logic             EX_V,
    input  logic [4:0]       EX_RD,
    input  logic             EX_WE,
    input  logic             EX_LD,
    input  logic             ME_V,
    input  logic [4:0]       ME_RD,
    input  logic             ME_WE,
    input  logic             ME_BRT,
    input  logic             WB_V,
    input  logic [4:0]       WB_RD,
    input  logic             WB_WE,
    output logic             PC_HOLD,
    output logic             EX_BUBBLE,
    output logic             KILL_DE,
    output logic             KILL_EX,
    output logic             KILL_ME,
    output logic             FREEZE,
    output logic [1:0]       FWD_A,
    output logic [1:0]       FWD_B,
    output logic             DE_BYP1,
    output logic             DE_BYP2,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT
);

    typedef enum logic [1:0] {RUN, LDUSE, HOLD} state_e;

    state_e           state_q, state_d;
    logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
    logic             redir, luse, run, stall;

    function automatic logic hit(input logic v, input logic we,
                                 input logic [4:0] rd, input logic [4:0] rs);
        return v & we & (rd != 5'd0) & (rd == rs);
    endfunction

    always_comb begin
        redir = ME_V & ME_BRT;
        luse  = EX_V & EX_LD & DE_V &
                ((hit(EX_V, EX_WE, EX_RD, DE_RS1) & DE_USE1) |
                 (hit(EX_V, EX_WE, EX_RD, DE_RS2) & DE_USE2));
        // EXT_HOLD outranks everything; reset forces every output low
        run   = !RST && !EXT_HOLD;
        stall = run && luse && !redir;

        PC_HOLD   = stall;
        EX_BUBBLE = stall;
        KILL_DE   = run && redir;
        KILL_EX   = run && redir;
        KILL_ME   = run && redir;
        FREEZE    = !RST && EXT_HOLD;
        DE_BYP1   = run && hit(WB_V, WB_WE, WB_RD, DE_RS1) && DE_USE1;
        DE_BYP2   = run && hit(WB_V, WB_WE, WB_RD, DE_RS2) && DE_USE2;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     state_d = EXT_HOLD ? HOLD : ((luse && !redir) ? LDUSE : RUN);
            LDUSE:   state_d = EXT_HOLD ? HOLD : RUN;
            HOLD:    state_d = EXT_HOLD ? HOLD : RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
        stall_d = stall_q;
        flush_d = flush_q;
        if (run) begin
            stall_d = stall_q + CNT_W'(stall);
            flush_d = flush_q + CNT_W'(redir);
            if (stall || redir) begin
                fwd_a_d = '0;
                fwd_b_d = '0;
            end else begin
                // nearer producer (EX) wins over ME; loads in EX cannot forward yet
                if (hit(EX_V, EX_WE, EX_RD, DE_RS1) && !EX_LD)  fwd_a_d = 2'd1;
                else if (hit(ME_V, ME_WE, ME_RD, DE_RS1))       fwd_a_d = 2'd2;
                else                                            fwd_a_d = 2'd0;
                if (hit(EX_V, EX_WE, EX_RD, DE_RS2) && !EX_LD)  fwd_b_d = 2'd1;
                else if (hit(ME_V, ME_WE, ME_RD, DE_RS2))       fwd_b_d = 2'd2;
                else                                            fwd_b_d = 2'd0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= RUN;
            fwd_a_q <= '0;
            fwd_b_q <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign FWD_A     = fwd_a_q;
    assign FWD_B     = fwd_b_q;
    assign STALL_CNT = stall_q;
    assign FLUSH_CNT = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: per-cycle stimulus tables with hand-derived
// expected outputs queued at drive time and compared when the DUT responds.
module tb_hazard_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        EXT_HOLD, DE_V, DE_USE1, DE_USE2, EX_V, EX_WE, EX_LD;
    logic        ME_V, ME_WE, ME_BRT, WB_V, WB_WE;
    logic [4:0]  DE_RS1, DE_RS2, EX_RD, ME_RD, WB_RD;
    logic        PC_HOLD, EX_BUBBLE, KILL_DE, KILL_EX, KILL_ME, FREEZE, DE_BYP1, DE_BYP2;
    logic [1:0]  FWD_A, FWD_B;
    logic [31:0] STALL_CNT, FLUSH_CNT;

    typedef struct packed {logic v; logic [4:0] rs1; logic [4:0] rs2; logic u1; logic u2;} de_t;
    typedef struct packed {logic v; logic [4:0] rd; logic we; logic ld;} exs_t;
    typedef struct packed {logic v; logic [4:0] rd; logic we; logic brt;} me_t;
    typedef struct packed {logic v; logic [4:0] rd; logic we;} wb_t;
    typedef struct packed {logic hold; de_t de; exs_t ex; me_t me; wb_t wb;} stim_t;
    typedef struct packed {logic [7:0] comb; logic [1:0] fa; logic [1:0] fb; logic [31:0] st; logic [31:0] fl;} exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    hazard_ctrl #(.CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .EXT_HOLD(EXT_HOLD),
        .DE_V(DE_V), .DE_RS1(DE_RS1), .DE_RS2(DE_RS2), .DE_USE1(DE_USE1), .DE_USE2(DE_USE2),
        .EX_V(EX_V), .EX_RD(EX_RD), .EX_WE(EX_WE), .EX_LD(EX_LD),
        .ME_V(ME_V), .ME_RD(ME_RD), .ME_WE(ME_WE), .ME_BRT(ME_BRT),
        .WB_V(WB_V), .WB_RD(WB_RD), .WB_WE(WB_WE),
        .PC_HOLD(PC_HOLD), .EX_BUBBLE(EX_BUBBLE), .KILL_DE(KILL_DE), .KILL_EX(KILL_EX),
        .KILL_ME(KILL_ME), .FREEZE(FREEZE), .FWD_A(FWD_A), .FWD_B(FWD_B),
        .DE_BYP1(DE_BYP1), .DE_BYP2(DE_BYP2), .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
    );

    initial forever #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    function automatic de_t de_f(int v, int r1, int r2, int u1, int u2);
        de_t d;
        d.v = v[0]; d.rs1 = r1[4:0]; d.rs2 = r2[4:0]; d.u1 = u1[0]; d.u2 = u2[0];
        return d;
    endfunction

    function automatic exs_t ex_f(int v, int rd, int we, int ld);
        exs_t x;
        x.v = v[0]; x.rd = rd[4:0]; x.we = we[0]; x.ld = ld[0];
        return x;
    endfunction

    function automatic me_t me_f(int v, int rd, int we, int brt);
        me_t m;
        m.v = v[0]; m.rd = rd[4:0]; m.we = we[0]; m.brt = brt[0];
        return m;
    endfunction

    function automatic wb_t wb_f(int v, int rd, int we);
        wb_t w;
        w.v = v[0]; w.rd = rd[4:0]; w.we = we[0];
        return w;
    endfunction

    function automatic stim_t mk(logic h, de_t d, exs_t x, me_t m, wb_t w);
        stim_t s;
        s.hold = h; s.de = d; s.ex = x; s.me = m; s.wb = w;
        return s;
    endfunction

    function automatic exp_t mkexp(logic [7:0] c, int fa, int fb, int st, int fl);
        exp_t e;
        e.comb = c; e.fa = fa[1:0]; e.fb = fb[1:0]; e.st = st; e.fl = fl;
        return e;
    endfunction

    function automatic logic [7:0] comb_o();
        return {PC_HOLD, EX_BUBBLE, KILL_DE, KILL_EX, KILL_ME, FREEZE, DE_BYP1, DE_BYP2};
    endfunction

    function automatic logic [67:0] regs_o();
        return {FWD_A, FWD_B, STALL_CNT, FLUSH_CNT};
    endfunction

    task automatic apply(stim_t s);
        EXT_HOLD = s.hold;
        DE_V = s.de.v; DE_RS1 = s.de.rs1; DE_RS2 = s.de.rs2; DE_USE1 = s.de.u1; DE_USE2 = s.de.u2;
        EX_V = s.ex.v; EX_RD = s.ex.rd; EX_WE = s.ex.we; EX_LD = s.ex.ld;
        ME_V = s.me.v; ME_RD = s.me.rd; ME_WE = s.me.we; ME_BRT = s.me.brt;
        WB_V = s.wb.v; WB_RD = s.wb.rd; WB_WE = s.wb.we;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        apply('0);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        exp_t cur;
        @(negedge CLK);
        RST = 1'b1;
        apply(mk(1'b1, de_f(1,5,5,1,1), ex_f(1,5,1,1), me_f(1,0,0,1), wb_f(1,5,1)));
        exp_q.push_back(mkexp(8'h00, 0, 0, 0, 0));
        #2;
        cur = exp_q[0];
        checks++;
        if (comb_o() !== cur.comb) begin
            errors++;
            $display("FAIL reset comb got %b required %b", comb_o(), cur.comb);
        end
        @(posedge CLK); #1;
        cur = exp_q.pop_front();
        checks++;
        if (regs_o() !== {cur.fa, cur.fb, cur.st, cur.fl}) begin
            errors++;
            $display("FAIL reset regs got %h required %h", regs_o(), {cur.fa, cur.fb, cur.st, cur.fl});
        end
        @(negedge CLK);
        RST = 1'b0;
        apply('0);
    endtask

    task automatic test_alu_fwd();
        stim_t s[4]; exp_t e[4]; exp_t cur;
        s[0] = mk(1'b0, de_f(1,5,1,1,1), ex_f(1,5,1,0), '0, '0);             e[0] = mkexp(8'h00, 1, 0, 0, 0);
        s[1] = mk(1'b0, de_f(1,1,5,1,1), ex_f(1,6,1,0), me_f(1,5,1,0), '0);  e[1] = mkexp(8'h00, 0, 2, 0, 0);
        s[2] = mk(1'b0, de_f(1,5,5,1,1), ex_f(1,5,1,0), me_f(1,5,1,0), '0);  e[2] = mkexp(8'h00, 1, 1, 0, 0);
        s[3] = '0;                                                            e[3] = mkexp(8'h00, 0, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            apply(s[i]);
            exp_q.push_back(e[i]);
            #2;
            cur = exp_q[0];
            checks++;
            if (comb_o() !== cur.comb) begin
                errors++;
                $display("FAIL alu_fwd[%0d] comb got %b required %b", i, comb_o(), cur.comb);
            end
            @(posedge CLK); #1;
            cur = exp_q.pop_front();
            checks++;
            if (regs_o() !== {cur.fa, cur.fb, cur.st, cur.fl}) begin
                errors++;
                $display("FAIL alu_fwd[%0d] regs got %h required %h", i, regs_o(), {cur.fa, cur.fb, cur.st, cur.fl});
            end
        end
    endtask

    task automatic test_load_use();
        stim_t s[3]; exp_t e[3]; exp_t cur;
        s[0] = mk(1'b0, de_f(1,5,1,1,1), ex_f(1,5,1,1), '0, '0);             e[0] = mkexp(8'b1100_0000, 0, 0, 1, 0);
        s[1] = mk(1'b0, de_f(1,5,1,1,1), '0, me_f(1,5,1,0), '0);             e[1] = mkexp(8'h00, 2, 0, 1, 0);
        s[2] = mk(1'b0, '0, ex_f(1,6,1,0), '0, wb_f(1,5,1));                 e[2] = mkexp(8'h00, 0, 0, 1, 0);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            apply(s[i]);
            exp_q.push_back(e[i]);
            #2;
            cur = exp_q[0];
            checks++;
            if (comb_o() !== cur.comb) begin
                errors++;
                $display("FAIL load_use[%0d] comb got %b required %b", i, comb_o(), cur.comb);
            end
            @(posedge CLK); #1;
            cur = exp_q.pop_front();
            checks++;
            if (regs_o() !== {cur.fa, cur.fb, cur.st, cur.fl}) begin
                errors++;
                $display("FAIL load_use[%0d] regs got %h required %h", i, regs_o(), {cur.fa, cur.fb, cur.st, cur.fl});
            end
        end
    endtask

    task automatic test_redirect();
        stim_t s[4]; exp_t e[4]; exp_t cur;
        s[0] = mk(1'b0, de_f(1,5,7,1,1), ex_f(1,5,1,1), me_f(1,0,0,1), '0);  e[0] = mkexp(8'b0011_1000, 0, 0, 0, 1);
        s[1] = mk(1'b0, de_f(1,5,0,1,0), ex_f(1,5,1,0), me_f(1,0,0,1), '0);  e[1] = mkexp(8'b0011_1000, 0, 0, 0, 2);
        s[2] = '0;                                                            e[2] = mkexp(8'h00, 0, 0, 0, 2);
        s[3] = mk(1'b0, '0, '0, me_f(0,0,0,1), '0);                          e[3] = mkexp(8'h00, 0, 0, 0, 2);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            apply(s[i]);
            exp_q.push_back(e[i]);
            #2;
            cur = exp_q[0];
            checks++;
            if (comb_o() !== cur.comb) begin
                errors++;
                $display("FAIL redirect[%0d] comb got %b required %b", i, comb_o(), cur.comb);
            end
            @(posedge CLK); #1;
            cur = exp_q.pop_front();
            checks++;
            if (regs_o() !== {cur.fa, cur.fb, cur.st, cur.fl}) begin
                errors++;
                $display("FAIL redirect[%0d] regs got %h required %h", i, regs_o(), {cur.fa, cur.fb, cur.st, cur.fl});
            end
        end
    endtask

    task automatic test_bypass_x0();
        stim_t s[6]; exp_t e[6]; exp_t cur;
        s[0] = mk(1'b0, de_f(1,3,5,1,1), '0, '0, wb_f(1,5,1));                           e[0] = mkexp(8'b0000_0001, 0, 0, 0, 0);
        s[1] = mk(1'b0, de_f(1,5,5,1,0), '0, '0, wb_f(1,5,1));                           e[1] = mkexp(8'b0000_0010, 0, 0, 0, 0);
        s[2] = mk(1'b0, de_f(1,0,0,1,1), ex_f(1,0,1,1), me_f(1,0,1,0), wb_f(1,0,1));     e[2] = mkexp(8'h00, 0, 0, 0, 0);
        s[3] = mk(1'b0, de_f(1,5,9,0,1), ex_f(1,5,1,1), '0, '0);                         e[3] = mkexp(8'h00, 0, 0, 0, 0);
        s[4] = mk(1'b0, de_f(0,5,5,1,1), ex_f(1,5,1,1), '0, '0);                         e[4] = mkexp(8'h00, 0, 0, 0, 0);
        s[5] = mk(1'b0, de_f(1,5,5,1,1), '0, '0, wb_f(1,5,0));                           e[5] = mkexp(8'h00, 0, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            apply(s[i]);
            exp_q.push_back(e[i]);
            #2;
            cur = exp_q[0];
            checks++;
            if (comb_o() !== cur.comb) begin
                errors++;
                $display("FAIL bypass_x0[%0d] comb got %b required %b", i, comb_o(), cur.comb);
            end
            @(posedge CLK); #1;
            cur = exp_q.pop_front();
            checks++;
            if (regs_o() !== {cur.fa, cur.fb, cur.st, cur.fl}) begin
                errors++;
                $display("FAIL bypass_x0[%0d] regs got %h required %h", i, regs_o(), {cur.fa, cur.fb, cur.st, cur.fl});
            end
        end
    endtask

    task automatic test_ext_hold();
        stim_t s[6]; exp_t e[6]; exp_t cur;
        s[0] = mk(1'b0, de_f(1,5,1,1,1), ex_f(1,5,1,1), '0, '0);             e[0] = mkexp(8'b1100_0000, 0, 0, 1, 0);
        s[1] = mk(1'b1, de_f(1,5,1,1,1), '0, me_f(1,5,1,0), '0);             e[1] = mkexp(8'b0000_0100, 0, 0, 1, 0);
        s[2] = mk(1'b1, de_f(1,5,1,1,1), '0, me_f(1,5,1,1), '0);             e[2] = mkexp(8'b0000_0100, 0, 0, 1, 0);
        s[3] = mk(1'b1, de_f(1,5,1,1,1), '0, me_f(1,5,1,0), '0);             e[3] = mkexp(8'b0000_0100, 0, 0, 1, 0);
        s[4] = mk(1'b0, de_f(1,5,1,1,1), '0, me_f(1,5,1,0), '0);             e[4] = mkexp(8'h00, 2, 0, 1, 0);
        s[5] = '0;                                                            e[5] = mkexp(8'h00, 0, 0, 1, 0);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            apply(s[i]);
            exp_q.push_back(e[i]);
            #2;
            cur = exp_q[0];
            checks++;
            if (comb_o() !== cur.comb) begin
                errors++;
                $display("FAIL ext_hold[%0d] comb got %b required %b", i, comb_o(), cur.comb);
            end
            @(posedge CLK); #1;
            cur = exp_q.pop_front();
            checks++;
            if (regs_o() !== {cur.fa, cur.fb, cur.st, cur.fl}) begin
                errors++;
                $display("FAIL ext_hold[%0d] regs got %h required %h", i, regs_o(), {cur.fa, cur.fb, cur.st, cur.fl});
            end
        end
    endtask

    task automatic test_reset_mid();
        stim_t s[4]; exp_t e[4]; logic r[4]; exp_t cur;
        // last two rows: reset asserted in LDUSE with hazards present, then first edge after release
        s[0] = mk(1'b0, '0, '0, me_f(1,0,0,1), '0);                                      e[0] = mkexp(8'b0011_1000, 0, 0, 0, 1); r[0] = 1'b0;
        s[1] = mk(1'b0, de_f(1,5,1,1,1), ex_f(1,5,1,1), '0, '0);                         e[1] = mkexp(8'b1100_0000, 0, 0, 1, 1); r[1] = 1'b0;
        s[2] = mk(1'b1, de_f(1,5,1,1,1), ex_f(1,5,1,1), me_f(1,0,0,1), wb_f(1,5,1));     e[2] = mkexp(8'h00, 0, 0, 0, 0);        r[2] = 1'b1;
        s[3] = mk(1'b0, de_f(1,5,1,1,1), '0, me_f(1,5,1,0), '0);                         e[3] = mkexp(8'h00, 2, 0, 0, 0);        r[3] = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            RST = r[i];
            apply(s[i]);
            exp_q.push_back(e[i]);
            #2;
            cur = exp_q[0];
            checks++;
            if (comb_o() !== cur.comb) begin
                errors++;
                $display("FAIL reset_mid[%0d] comb got %b required %b", i, comb_o(), cur.comb);
            end
            @(posedge CLK); #1;
            cur = exp_q.pop_front();
            checks++;
            if (regs_o() !== {cur.fa, cur.fb, cur.st, cur.fl}) begin
                errors++;
                $display("FAIL reset_mid[%0d] regs got %h required %h", i, regs_o(), {cur.fa, cur.fb, cur.st, cur.fl});
            end
        end
    endtask

    initial begin
        RST = 1'b1;
        apply('0);
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_redirect();
        test_bypass_x0();
        test_ext_hold();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
